// File: rtl/timestamp_pkg.sv
// Shared constants for the timestamp counter and capture path.
package timestamp_pkg;

  localparam int unsigned TS_W      = 64;
  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned DROP_W    = 8;

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser plus history flop; emits a one-cycle pulse per synchronised rising edge.
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic evt_i,
  output logic rise_o
);

  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic       s3_q, s3_d;
  logic [2:0] vld_q, vld_d;

  always_comb begin
    s1_d  = evt_i;
    s2_d  = s1_q;
    s3_d  = s2_q;
    vld_d = {vld_q[1:0], 1'b1};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      vld_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
      vld_q <= vld_d;
    end
  end

  // Only flag an edge once s2 and s3 both hold real samples, so a line high at reset release is
  // not mistaken for a rising edge.
  assign rise_o = s2_q & ~s3_q & vld_q[2];

endmodule

// File: rtl/timestamp_capture.sv
// Captures count_in on each synchronised evt_in rising edge into a FWFT FIFO with drop tracking.
module timestamp_capture
  import timestamp_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned TS_WIDTH = TS_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [TS_WIDTH-1:0]      count_in,
  input  logic                     evt_in,
  input  logic                     rd_en,
  input  logic                     clear_ovf,
  output logic [TS_WIDTH-1:0]      ts_out,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = $clog2(DEPTH) + 1;

  logic [TS_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]     level_q, level_d;
  logic                overflow_q, overflow_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                rise, do_pop, do_push, do_drop;

  sync_edge_detect u_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .evt_i  (evt_in),
    .rise_o (rise)
  );

  assign empty = (level_q == '0);
  assign full  = (level_q == LvlW'(DEPTH));

  always_comb begin
    do_pop  = rd_en & ~empty;
    do_push = rise & (~full | do_pop);
    do_drop = rise & full & ~do_pop;

    wr_ptr_d = wr_ptr_q + PtrW'(do_push);
    rd_ptr_d = rd_ptr_q + PtrW'(do_pop);

    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LvlW'(1);
    end else if (do_pop && !do_push) begin
      level_d = level_q - LvlW'(1);
    end

    // A drop in the same cycle as clear_ovf wins: the clear is absorbed and this drop is counted.
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (do_drop) begin
      overflow_d = 1'b1;
      if (clear_ovf) begin
        drop_d = DROP_W'(1);
      end else if (drop_q != DROP_MAX) begin
        drop_d = drop_q + DROP_W'(1);
      end
    end else if (clear_ovf) begin
      overflow_d = 1'b0;
      drop_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage is deliberately left out of reset; it is only observable through ts_out when non-empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= count_in;
    end
  end

  assign ts_out     = mem_q[rd_ptr_q];
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_timestamp_capture.sv
// Randomised and directed bench for timestamp_capture against a queue-based reference model.
module tb_timestamp_capture;
  import timestamp_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [TS_W-1:0]   count_in;
  logic              evt_in;
  logic              rd_en;
  logic              clear_ovf;
  logic [TS_W-1:0]   ts_out;
  logic              empty;
  logic              full;
  logic [3:0]        level;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;

  timestamp_capture #(
    .DEPTH    (DEPTH),
    .TS_WIDTH (TS_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .count_in   (count_in),
    .evt_in     (evt_in),
    .rd_en      (rd_en),
    .clear_ovf  (clear_ovf),
    .ts_out     (ts_out),
    .empty      (empty),
    .full       (full),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of stored timestamps, drop bookkeeping, and the recent post-reset
  // history of evt_in as seen at each clock edge.
  logic [TS_W-1:0] mq[$];
  int              m_drop;
  bit              m_ovf;
  bit              h1, h2, h3;
  int              nsamp;
  logic [TS_W-1:0] cbase;
  logic [TS_W-1:0] edge_no;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    check("empty", 64'(empty), 64'(mq.size() == 0));
    check("full", 64'(full), 64'(mq.size() == DEPTH));
    check("level", 64'(level), 64'(mq.size()));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("drop_count", 64'(drop_count), 64'(m_drop));
    if (mq.size() > 0) check("ts_out", ts_out, mq[0]);
  endtask

  // Drive one clock cycle of inputs (called at a negedge) and advance the model by one edge.
  task automatic step(input bit evt, input bit rd, input bit clr);
    bit cap, pop;
    evt_in    = evt;
    rd_en     = rd;
    clear_ovf = clr;
    edge_no   = edge_no + 1;
    count_in  = cbase + edge_no;
    // An event seen high at edge k after being low at edge k-1 (both after reset) lands at k+2.
    cap = (nsamp >= 3) && h2 && !h3;
    pop = rd && (mq.size() > 0);
    if (cap && mq.size() == DEPTH && !pop) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
    end else begin
      if (clr) begin
        m_ovf  = 1'b0;
        m_drop = 0;
      end
      if (pop) void'(mq.pop_front());
      if (cap) mq.push_back(count_in);
    end
    h3 = h2;
    h2 = h1;
    h1 = evt;
    nsamp++;
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  task automatic do_reset(input bit evt_hold);
    evt_in    = evt_hold;
    rd_en     = 1'b0;
    clear_ovf = 1'b0;
    rst       = 1'b1;
    #1;
    mq.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
    nsamp  = 0;
    h1 = 1'b0;
    h2 = 1'b0;
    h3 = 1'b0;
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    edge_no = '0;
  endtask

  logic [TS_W-1:0] exp_head;

  initial begin
    rst       = 1'b1;
    evt_in    = 1'b0;
    rd_en     = 1'b0;
    clear_ovf = 1'b0;
    count_in  = '0;
    cbase     = 64'd1000;
    edge_no   = '0;
    do_reset(1'b0);

    // Single capture: evt_in first high at edge 10, captured at edge 12.
    for (int i = 1; i <= 12; i++) step(i >= 10, 1'b0, 1'b0);
    check("single_level", 64'(level), 64'd1);
    check("single_ts", ts_out, 64'd1012);
    step(1'b0, 1'b1, 1'b0);

    // Ten events, no reads: eight stored, two dropped.
    repeat (10) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("fill_full", 64'(full), 64'd1);
    check("fill_level", 64'(level), 64'd8);
    check("fill_ovf", 64'(overflow), 64'd1);
    check("fill_drop", 64'(drop_count), 64'd2);

    // Clear, then write and pop together while full.
    step(1'b0, 1'b0, 1'b1);
    exp_head = mq[1];
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("wrpop_level", 64'(level), 64'd8);
    check("wrpop_ovf", 64'(overflow), 64'd0);
    check("wrpop_head", ts_out, exp_head);

    // Drain, then read while empty, then a fresh capture must become the head.
    repeat (8) step(1'b0, 1'b1, 1'b0);
    check("drain_empty", 64'(empty), 64'd1);
    repeat (5) step(1'b0, 1'b1, 1'b0);
    check("rdempty_level", 64'(level), 64'd0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("rdempty_ts", ts_out, count_in);
    check("rdempty_lvl1", 64'(level), 64'd1);

    // Clear versus drop with drop_count at 5.
    step(1'b0, 1'b0, 1'b1);
    repeat (12) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0);
    check("clrdrop_pre", 64'(drop_count), 64'd5);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("clrdrop_ovf", 64'(overflow), 64'd1);
    check("clrdrop_cnt", 64'(drop_count), 64'd1);

    // Saturation of drop_count.
    repeat (260) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0);
    check("sat_drop", 64'(drop_count), 64'd255);

    // Reset mid-operation at level 5 with evt_in held high through release.
    step(1'b0, 1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b1, 1'b0);
    check("mid_level5", 64'(level), 64'd5);
    do_reset(1'b1);
    repeat (6) step(1'b1, 1'b0, 1'b0);
    check("mid_nocap", 64'(level), 64'd0);
    step(1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    check("mid_recap", 64'(level), 64'd1);

    // Randomised traffic.
    cbase = {$urandom, $urandom};
    repeat (3000) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4, $urandom_range(0, 99) < 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
